mips_multicycle_ctrl: RTL
=========================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameter: OPCODE_W, 6, instruction opcode field width.
REQ-002 Parameter: FUNCT_W, 6, R-type funct field width.
REQ-003 One clock; reset is asynchronous and active-low. Ports: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  OPCODE_W  instr[31:26] from instruction register.
REQ-006 funct  input  FUNCT_W  instr[5:0].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 pc_en  output  1  PC load = pc_write | (branch & zero).
REQ-009 iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each  standard multicycle datapath selects.
REQ-010 alu_src_b  output  2  00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2.
REQ-011 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-012 alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-013 ext_zero  output  1  immediate extender mode: 0 sign-extend, 1 zero-extend.
REQ-014 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-015 state_dbg  output  4  current state encoding.

Function
REQ-016 Moore FSM, registered state; all outputs combinational from state (alu_control also from funct in EXECUTE).
REQ-017 States: RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP.
REQ-018 RST: all outputs 0; next state FETCH unconditionally.
REQ-019 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu add, pc_src=00, ir_write=1, pc_write=1; -> DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu add, ext_zero=0 (branch target). Opcode 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> IMMEXEC; 000010 -> JUMP; other -> FETCH with illegal_op=1 that cycle.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, add, ext_zero=0; lw -> MEMRD, sw -> MEMWR.
REQ-022 MEMRD: iord=1 -> MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH. MEMWR: iord=1, mem_write=1 -> FETCH.
REQ-023 EXECUTE: alu_src_a=1, alu_src_b=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other add; -> ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1 -> FETCH; pc_en = zero.
REQ-025 IMMEXEC: alu_src_a=1, alu_src_b=10, add, ext_zero=0 -> IMMWB. IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0, same ALU/ext settings held -> FETCH.
REQ-026 JUMP: pc_src=10, pc_write=1 -> FETCH.
REQ-027 Instruction latency in cycles from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-028 Outputs not listed for a state are 0; ext_zero=0 unless stated.

Reset
REQ-029 rst_n low forces state RST asynchronously, from any state mid-instruction; all outputs 0 while low; first FETCH one cycle after release.

Configuration
REQ-030 MIPS_LOGIC_IMM_EN defined: opcodes 001100 (andi) and 001101 (ori) -> IMMEXEC with ext_zero=1 and alu_control and/or in IMMEXEC and IMMWB; opcode latched in DECODE to select.
REQ-031 MIPS_LOGIC_IMM_EN undefined: 001100/001101 treated as illegal per REQ-020; ext_zero constant 0.

Structure
REQ-032 Package mips_pkg: opcode and funct constants, alu_control codes, state enumeration.
REQ-033 One sub-module alu_decoder (funct + op class -> alu_control); FSM in top.

Verification
REQ-034 Release rst_n, opcode=100011: state sequence RST,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1 and mem_to_reg=1 only in MEMWB.
REQ-035 opcode=000100, zero=1 then zero=0: pc_en=1 in BRANCH only when zero=1; pc_src=01.
REQ-036 opcode=000000, funct=101010: alu_control=111 in EXECUTE; ALUWB reg_dst=1.
REQ-037 opcode=111111: illegal_op=1 for exactly one cycle in DECODE, next state FETCH.
REQ-038 With MIPS_LOGIC_IMM_EN, opcode=001101: ext_zero=1, alu_control=001 in IMMEXEC/IMMWB; without macro: illegal_op pulse.
REQ-039 rst_n low during MEMWR: mem_write drops to 0 immediately, state RST, FETCH resumes after release.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, ALU control codes and FSM state encoding
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_IMMEXEC = 4'd10,
        S_IMMWB   = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    // Operation class requested by the FSM; AOP_NONE drives a quiet all-zero control
    typedef enum logic [2:0] {
        AOP_NONE  = 3'd0,
        AOP_ADD   = 3'd1,
        AOP_SUB   = 3'd2,
        AOP_FUNCT = 3'd3,
        AOP_AND   = 3'd4,
        AOP_OR    = 3'd5
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM operation class (and R-type funct) to the 3-bit ALU control
module alu_decoder
    import mips_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [FUNCT_W-1:0] funct,
    input  alu_op_t            alu_op,
    output logic [2:0]         alu_control
);

    logic [2:0] funct_ctrl;

    // R-type funct decode; unrecognised functs fall back to add
    always_comb begin
        funct_ctrl = ALU_ADD;
        case (funct)
            FN_ADD:  funct_ctrl = ALU_ADD;
            FN_SUB:  funct_ctrl = ALU_SUB;
            FN_AND:  funct_ctrl = ALU_AND;
            FN_OR:   funct_ctrl = ALU_OR;
            FN_SLT:  funct_ctrl = ALU_SLT;
            default: funct_ctrl = ALU_ADD;
        endcase
    end

    // Operation class selects a fixed code or defers to the funct decode
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            AOP_ADD:   alu_control = ALU_ADD;
            AOP_SUB:   alu_control = ALU_SUB;
            AOP_FUNCT: alu_control = funct_ctrl;
            AOP_AND:   alu_control = ALU_AND;
            AOP_OR:    alu_control = ALU_OR;
            default:   alu_control = 3'b000;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath
// Define MIPS_LOGIC_IMM_EN to add andi/ori (zero-extended immediate logic ops).
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    output logic                pc_en,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic [2:0]          alu_control,
    output logic                ext_zero,
    output logic                illegal_op,
    output logic [3:0]          state_dbg
);

    state_t  state, next_state;
    alu_op_t alu_op;
    alu_op_t imm_op;
    logic    imm_zx;
    logic    logic_imm;
    logic    pc_write;
    logic    branch;

`ifdef MIPS_LOGIC_IMM_EN
    assign logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

    // Capture the immediate flavour in DECODE so IMMEXEC/IMMWB hold it steadily
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_op <= AOP_ADD;
            imm_zx <= 1'b0;
        end else if (state == S_DECODE) begin
            imm_op <= (opcode == OP_ANDI) ? AOP_AND : (opcode == OP_ORI) ? AOP_OR : AOP_ADD;
            imm_zx <= logic_imm;
        end
    end
`else
    assign logic_imm = 1'b0;
    assign imm_op    = AOP_ADD;
    assign imm_zx    = 1'b0;
`endif

    // State register; reset can abort any instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= next_state;
    end

    // Next-state and Moore outputs; DECODE also flags unsupported opcodes
    always_comb begin
        next_state = S_FETCH;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = AOP_NONE;
        ext_zero   = 1'b0;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                alu_src_b  = 2'b01;
                alu_op     = AOP_ADD;
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                alu_op     = AOP_ADD;
                next_state = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                             (opcode == OP_RTYPE)                 ? S_EXECUTE :
                             (opcode == OP_BEQ)                   ? S_BRANCH :
                             (opcode == OP_ADDI || logic_imm)     ? S_IMMEXEC :
                             (opcode == OP_J)                     ? S_JUMP : S_FETCH;
                illegal_op = (next_state == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = AOP_ADD;
                next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord       = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_op     = AOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = AOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_IMMEXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = imm_op;
                ext_zero   = imm_zx;
                next_state = S_IMMWB;
            end
            S_IMMWB: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_op;
                ext_zero  = imm_zx;
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign pc_en     = pc_write | (branch & zero);
    assign state_dbg = state;

    alu_decoder #(.FUNCT_W(FUNCT_W)) u_alu_decoder (
        .funct       (funct),
        .alu_op      (alu_op),
        .alu_control (alu_control)
    );

endmodule
